// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_pkg
// Brief    : Response codes, FSM encodings and byte-lane merge helper for the
//            AXI4-Lite SRAM slave.
// Revision : 1.0
// ============================================================================
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_WAIT_W = 2'd1,
        WR_WAIT_A = 2'd2,
        WR_RESP   = 2'd3
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] strb_merge(
        input logic [31:0] i_old,
        input logic [31:0] i_new,
        input logic [3:0]  i_strb
    );
        logic [31:0] w_merged;
        w_merged = i_old;
        for (int i = 0; i < 4; i++) begin
            if (i_strb[i]) begin
                w_merged[8*i +: 8] = i_new[8*i +: 8];
            end
        end
        return w_merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_strb_ram.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_strb_ram
// Brief    : 32-bit word memory with byte-enable write port, registered read
//            port and synchronous clear of contents and read register.
// Revision : 1.0
// ============================================================================
module axi4_lite_strb_ram
    import axi4_lite_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [31:0]      i_wdata,
    input  logic [3:0]       i_wstrb,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Read samples the array before this edge's write lands, so a colliding
    // read returns the old word.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_waddr] <= strb_merge(r_mem[i_waddr], i_wdata, i_wstrb);
            end
            if (i_re) begin
                r_rdata <= r_mem[i_raddr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/axi4_lite_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_sram_slave
// Brief    : AXI4-Lite slave fronting a byte-strobed SRAM with independent
//            read and write channel FSMs.
// Revision : 1.0
// ============================================================================
module axi4_lite_sram_slave
    import axi4_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h00000100,
    parameter int                    DEPTH      = 64
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    s_AWVALID,
    input  logic [ADDR_WIDTH-1:0]   s_AWADDR,
    input  logic [2:0]              s_AWPROT,
    output logic                    s_AWREADY,
    input  logic                    s_WVALID,
    input  logic [DATA_WIDTH-1:0]   s_WDATA,
    input  logic [DATA_WIDTH/8-1:0] s_WSTRB,
    output logic                    s_WREADY,
    input  logic                    s_BREADY,
    output logic                    s_BVALID,
    output logic [1:0]              s_BRESP,
    input  logic                    s_ARVALID,
    input  logic [ADDR_WIDTH-1:0]   s_ARADDR,
    input  logic [2:0]              s_ARPROT,
    output logic                    s_ARREADY,
    input  logic                    s_RREADY,
    output logic                    s_RVALID,
    output logic [1:0]              s_RRESP,
    output logic [DATA_WIDTH-1:0]   s_RDATA
);

    localparam int                  IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] c_SPAN = (ADDR_WIDTH+1)'(4 * DEPTH);

    wr_state_t                 r_wr_state;
    rd_state_t                 r_rd_state;
    logic [ADDR_WIDTH-1:0]     r_aw_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH/8-1:0]   r_wstrb;
    logic                      r_bvalid;
    logic [1:0]                r_bresp;
    logic                      r_rvalid;
    logic [1:0]                r_rresp;
    logic                      r_rd_oor;

    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_ar_hs;
    logic                      w_wr_fire;
    logic [ADDR_WIDTH-1:0]     w_wr_addr;
    logic [DATA_WIDTH-1:0]     w_wr_data;
    logic [DATA_WIDTH/8-1:0]   w_wr_strb;
    logic [ADDR_WIDTH:0]       w_wr_off;
    logic [ADDR_WIDTH:0]       w_rd_off;
    logic                      w_wr_in_range;
    logic                      w_rd_in_range;
    logic [31:0]               w_ram_rdata;
    logic                      w_unused;

    assign s_AWREADY = iRST && ((r_wr_state == WR_IDLE) || (r_wr_state == WR_WAIT_A));
    assign s_WREADY  = iRST && ((r_wr_state == WR_IDLE) || (r_wr_state == WR_WAIT_W));
    assign s_ARREADY = iRST && (r_rd_state == RD_IDLE);

    assign w_aw_hs = s_AWVALID && s_AWREADY;
    assign w_w_hs  = s_WVALID  && s_WREADY;
    assign w_ar_hs = s_ARVALID && s_ARREADY;

    // Whichever half arrived first comes from the holding register.
    assign w_wr_addr = (r_wr_state == WR_WAIT_W) ? r_aw_addr : s_AWADDR;
    assign w_wr_data = (r_wr_state == WR_WAIT_A) ? r_wdata   : s_WDATA;
    assign w_wr_strb = (r_wr_state == WR_WAIT_A) ? r_wstrb   : s_WSTRB;

    assign w_wr_fire = ((r_wr_state == WR_IDLE)   && w_aw_hs && w_w_hs) ||
                       ((r_wr_state == WR_WAIT_W) && w_w_hs) ||
                       ((r_wr_state == WR_WAIT_A) && w_aw_hs);

    // Extra top bit catches addresses below the base as a huge offset.
    assign w_wr_off      = {1'b0, w_wr_addr} - {1'b0, BASE_ADDR};
    assign w_rd_off      = {1'b0, s_ARADDR}  - {1'b0, BASE_ADDR};
    assign w_wr_in_range = (w_wr_off < c_SPAN);
    assign w_rd_in_range = (w_rd_off < c_SPAN);

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_wr_state <= WR_IDLE;
            r_aw_addr  <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            case (r_wr_state)
                WR_IDLE: begin
                    if (w_aw_hs && w_w_hs) begin
                        r_wr_state <= WR_RESP;
                    end else if (w_aw_hs) begin
                        r_aw_addr  <= s_AWADDR;
                        r_wr_state <= WR_WAIT_W;
                    end else if (w_w_hs) begin
                        r_wdata    <= s_WDATA;
                        r_wstrb    <= s_WSTRB;
                        r_wr_state <= WR_WAIT_A;
                    end
                end
                WR_WAIT_W: begin
                    if (w_w_hs) begin
                        r_wr_state <= WR_RESP;
                    end
                end
                WR_WAIT_A: begin
                    if (w_aw_hs) begin
                        r_wr_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (s_BREADY) begin
                        r_bvalid   <= 1'b0;
                        r_wr_state <= WR_IDLE;
                    end
                end
            endcase
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_rd_state <= RD_IDLE;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rd_oor   <= 1'b0;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (w_ar_hs) begin
                        r_rvalid   <= 1'b1;
                        r_rresp    <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
                        r_rd_oor   <= !w_rd_in_range;
                        r_rd_state <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (s_RREADY) begin
                        r_rvalid   <= 1'b0;
                        r_rd_state <= RD_IDLE;
                    end
                end
            endcase
        end
    end

    axi4_lite_strb_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .i_clk   (iCLK),
        .i_clr   (!iRST),
        .i_we    (w_wr_fire && w_wr_in_range),
        .i_waddr (w_wr_off[IDX_W+1:2]),
        .i_wdata (w_wr_data),
        .i_wstrb (w_wr_strb),
        .i_re    (w_ar_hs && w_rd_in_range),
        .i_raddr (w_rd_off[IDX_W+1:2]),
        .o_rdata (w_ram_rdata)
    );

    assign s_BVALID = r_bvalid;
    assign s_BRESP  = r_bresp;
    assign s_RVALID = r_rvalid;
    assign s_RRESP  = r_rresp;
    assign s_RDATA  = r_rd_oor ? '0 : w_ram_rdata;

    assign w_unused = ^{s_AWPROT, s_ARPROT,
                        w_wr_off[ADDR_WIDTH:IDX_W+2], w_wr_off[1:0],
                        w_rd_off[ADDR_WIDTH:IDX_W+2], w_rd_off[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_sram_slave
// Brief    : Self-checking bench for axi4_lite_sram_slave against a word-array
//            reference model.
// Revision : 1.0
// ============================================================================
module tb_axi4_lite_sram_slave;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h00000100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_AWVALID = 0, s_AWREADY;
    logic [31:0] s_AWADDR = '0;
    logic [2:0]  s_AWPROT = '0;
    logic        s_WVALID = 0, s_WREADY;
    logic [31:0] s_WDATA = '0;
    logic [3:0]  s_WSTRB = '0;
    logic        s_BREADY = 0, s_BVALID;
    logic [1:0]  s_BRESP;
    logic        s_ARVALID = 0, s_ARREADY;
    logic [31:0] s_ARADDR = '0;
    logic [2:0]  s_ARPROT = '0;
    logic        s_RREADY = 0, s_RVALID;
    logic [1:0]  s_RRESP;
    logic [31:0] s_RDATA;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    axi4_lite_sram_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BASE_ADDR  (BASE),
        .DEPTH      (DEPTH)
    ) dut (
        .iCLK      (clk),
        .iRST      (rst_n),
        .s_AWVALID (s_AWVALID),
        .s_AWADDR  (s_AWADDR),
        .s_AWPROT  (s_AWPROT),
        .s_AWREADY (s_AWREADY),
        .s_WVALID  (s_WVALID),
        .s_WDATA   (s_WDATA),
        .s_WSTRB   (s_WSTRB),
        .s_WREADY  (s_WREADY),
        .s_BREADY  (s_BREADY),
        .s_BVALID  (s_BVALID),
        .s_BRESP   (s_BRESP),
        .s_ARVALID (s_ARVALID),
        .s_ARADDR  (s_ARADDR),
        .s_ARPROT  (s_ARPROT),
        .s_ARREADY (s_ARREADY),
        .s_RREADY  (s_RREADY),
        .s_RVALID  (s_RVALID),
        .s_RRESP   (s_RRESP),
        .s_RDATA   (s_RDATA)
    );

    function automatic bit mdl_in_range(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
    endfunction

    function automatic logic [1:0] mdl_write(input logic [31:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
        int idx;
        if (!mdl_in_range(a)) return 2'b10;
        idx = int'((a - BASE) / 4);
        for (int i = 0; i < 4; i++) if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
        return 2'b00;
    endfunction

    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        if (!mdl_in_range(a)) return 32'h0;
        return model[int'((a - BASE) / 4)];
    endfunction

    function automatic logic [1:0] mdl_resp(input logic [31:0] a);
        return mdl_in_range(a) ? 2'b00 : 2'b10;
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    // Drives one write with independent AW/W start delays, then holds BREADY
    // low for 'hold' cycles before accepting the response.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int hold, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_now, w_now;
        int cyc = 0;
        resp = 2'bxx;
        while (!(aw_done && w_done)) begin
            if (!aw_done && cyc >= aw_dly) begin
                s_AWVALID = 1; s_AWADDR = addr; s_AWPROT = 3'($urandom);
            end
            if (!w_done && cyc >= w_dly) begin
                s_WVALID = 1; s_WDATA = data; s_WSTRB = strb;
            end
            aw_now = s_AWVALID && s_AWREADY;
            w_now  = s_WVALID && s_WREADY;
            @(posedge clk); #1;
            if (aw_now) begin aw_done = 1; s_AWVALID = 0; end
            if (w_now)  begin w_done = 1;  s_WVALID = 0;  end
            cyc++;
            if (!(aw_done && w_done)) begin
                checks++;
                if (s_BVALID !== 1'b0) begin
                    errors++;
                    $display("FAIL wr_early_bvalid addr=%h: BVALID=%b, want 0", addr, s_BVALID);
                end
            end
            if (cyc > 40) begin
                checks++; errors++;
                $display("FAIL wr_timeout addr=%h: handshakes aw=%0d w=%0d, want both", addr, aw_done, w_done);
                s_AWVALID = 0; s_WVALID = 0;
                return;
            end
        end
        checks++;
        if (s_BVALID !== 1'b1) begin
            errors++;
            $display("FAIL wr_bvalid addr=%h: BVALID=%b one cycle after handshake, want 1", addr, s_BVALID);
        end
        resp = s_BRESP;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (s_BVALID !== 1'b1 || s_BRESP !== resp || s_AWREADY !== 1'b0 || s_WREADY !== 1'b0) begin
                errors++;
                $display("FAIL wr_hold cyc=%0d: BVALID=%b BRESP=%b AWREADY=%b WREADY=%b, want 1 %b 0 0",
                         i, s_BVALID, s_BRESP, s_AWREADY, s_WREADY, resp);
            end
        end
        s_BREADY = 1;
        @(posedge clk); #1;
        s_BREADY = 0;
        checks++;
        if (s_BVALID !== 1'b0) begin
            errors++;
            $display("FAIL wr_bclear addr=%h: BVALID=%b after BREADY, want 0", addr, s_BVALID);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold,
                           output logic [31:0] data, output logic [1:0] resp);
        bit hs;
        int cyc = 0;
        data = 'x; resp = 'x;
        s_ARVALID = 1; s_ARADDR = addr; s_ARPROT = 3'($urandom);
        while (1) begin
            hs = s_ARREADY;
            @(posedge clk); #1;
            if (hs) break;
            cyc++;
            if (cyc > 40) begin
                checks++; errors++;
                $display("FAIL rd_timeout addr=%h: ARREADY=%b, want 1", addr, s_ARREADY);
                s_ARVALID = 0;
                return;
            end
        end
        s_ARVALID = 0;
        checks++;
        if (s_RVALID !== 1'b1) begin
            errors++;
            $display("FAIL rd_rvalid addr=%h: RVALID=%b one cycle after AR, want 1", addr, s_RVALID);
        end
        data = s_RDATA; resp = s_RRESP;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (s_RVALID !== 1'b1 || s_RDATA !== data || s_RRESP !== resp || s_ARREADY !== 1'b0) begin
                errors++;
                $display("FAIL rd_hold cyc=%0d: RVALID=%b RDATA=%h RRESP=%b ARREADY=%b, want 1 %h %b 0",
                         i, s_RVALID, s_RDATA, s_RRESP, s_ARREADY, data, resp);
            end
        end
        s_RREADY = 1;
        @(posedge clk); #1;
        s_RREADY = 0;
        checks++;
        if (s_RVALID !== 1'b0) begin
            errors++;
            $display("FAIL rd_rclear addr=%h: RVALID=%b after RREADY, want 0", addr, s_RVALID);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_AWREADY !== 1'b0 || s_WREADY !== 1'b0 || s_ARREADY !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: AW/W/AR READY=%b%b%b, want 000", s_AWREADY, s_WREADY, s_ARREADY);
        end
        rst_n = 1;
        #1;
        mdl_clear();
        checks++;
        if (s_BVALID !== 1'b0 || s_RVALID !== 1'b0 || s_BRESP !== 2'b00 ||
            s_RRESP !== 2'b00 || s_RDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: BV=%b RV=%b BRESP=%b RRESP=%b RDATA=%h, want 0 0 00 00 0",
                     s_BVALID, s_RVALID, s_BRESP, s_RRESP, s_RDATA);
        end
        checks++;
        if (s_AWREADY !== 1'b1 || s_WREADY !== 1'b1 || s_ARREADY !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: AW/W/AR READY=%b%b%b, want 111", s_AWREADY, s_WREADY, s_ARREADY);
        end
    endtask

    task automatic test_basic();
        logic [1:0] br, rr, exp_r;
        logic [31:0] rd;
        exp_r = mdl_write(32'h100, 32'hDEADBEEF, 4'hF);
        do_write(32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, br);
        checks++;
        if (br !== exp_r) begin errors++; $display("FAIL basic_bresp: got %b want %b", br, exp_r); end
        do_read(32'h100, 0, rd, rr);
        checks++;
        if (rd !== 32'hDEADBEEF || rr !== 2'b00) begin
            errors++; $display("FAIL basic_read: got %h/%b want deadbeef/00", rd, rr);
        end
    endtask

    task automatic test_split();
        logic [1:0] br, rr, exp_r;
        logic [31:0] rd;
        exp_r = mdl_write(32'h110, 32'h99AABBCC, 4'hF);
        do_write(32'h110, 32'h99AABBCC, 4'hF, 0, 3, 0, br);
        checks++;
        if (br !== exp_r) begin errors++; $display("FAIL split_aw_first_bresp: got %b want %b", br, exp_r); end
        exp_r = mdl_write(32'h104, 32'h11223344, 4'hF);
        do_write(32'h104, 32'h11223344, 4'hF, 3, 0, 0, br);
        checks++;
        if (br !== exp_r) begin errors++; $display("FAIL split_w_first_bresp: got %b want %b", br, exp_r); end
        do_read(32'h104, 0, rd, rr);
        checks++;
        if (rd !== mdl_read(32'h104) || rr !== 2'b00) begin
            errors++; $display("FAIL split_read104: got %h/%b want %h/00", rd, rr, mdl_read(32'h104));
        end
        do_read(32'h110, 0, rd, rr);
        checks++;
        if (rd !== mdl_read(32'h110) || rr !== 2'b00) begin
            errors++; $display("FAIL split_read110: got %h/%b want %h/00", rd, rr, mdl_read(32'h110));
        end
    endtask

    task automatic test_strobe();
        logic [1:0] br, rr;
        logic [31:0] rd;
        logic [3:0]  strbs [4] = '{4'hF, 4'b0001, 4'b0000, 4'b1010};
        logic [31:0] datas [4] = '{32'hAABBCCDD, 32'h00000055, 32'hFFFFFFFF, 32'h12345678};
        for (int i = 0; i < 4; i++) begin
            void'(mdl_write(32'h108, datas[i], strbs[i]));
            do_write(32'h108, datas[i], strbs[i], 0, 0, 0, br);
            checks++;
            if (br !== 2'b00) begin errors++; $display("FAIL strobe_bresp step=%0d: got %b want 00", i, br); end
            do_read(32'h108, 0, rd, rr);
            checks++;
            if (rd !== mdl_read(32'h108)) begin
                errors++; $display("FAIL strobe_read step=%0d: got %h want %h", i, rd, mdl_read(32'h108));
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] br, rr;
        logic [31:0] rd;
        logic [31:0] addrs [6] = '{32'h200, 32'h0FC, 32'h0FF, 32'h1FC, 32'h1FF, 32'h103};
        for (int i = 0; i < 6; i++) begin
            logic [1:0] exp_b;
            exp_b = mdl_write(addrs[i], 32'hC0DE0000 + 32'(i), 4'hF);
            do_write(addrs[i], 32'hC0DE0000 + 32'(i), 4'hF, 0, 0, 0, br);
            checks++;
            if (br !== exp_b) begin errors++; $display("FAIL range_bresp addr=%h: got %b want %b", addrs[i], br, exp_b); end
            do_read(addrs[i], 0, rd, rr);
            checks++;
            if (rd !== mdl_read(addrs[i]) || rr !== mdl_resp(addrs[i])) begin
                errors++;
                $display("FAIL range_read addr=%h: got %h/%b want %h/%b", addrs[i], rd, rr,
                         mdl_read(addrs[i]), mdl_resp(addrs[i]));
            end
        end
        for (int w = 0; w < DEPTH; w++) begin
            do_read(BASE + 32'(4 * w), 0, rd, rr);
            checks++;
            if (rd !== model[w]) begin
                errors++; $display("FAIL range_sweep word=%0d: got %h want %h", w, rd, model[w]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] br, rr;
        logic [31:0] rd;
        void'(mdl_write(32'h120, 32'h5A5AA5A5, 4'hF));
        do_write(32'h120, 32'h5A5AA5A5, 4'hF, 1, 0, 5, br);
        checks++;
        if (br !== 2'b00) begin errors++; $display("FAIL bp_bresp: got %b want 00", br); end
        do_read(32'h120, 5, rd, rr);
        checks++;
        if (rd !== 32'h5A5AA5A5 || rr !== 2'b00) begin
            errors++; $display("FAIL bp_read: got %h/%b want 5a5aa5a5/00", rd, rr);
        end
        do_read(32'h300, 5, rd, rr);
        checks++;
        if (rd !== 32'h0 || rr !== 2'b10) begin
            errors++; $display("FAIL bp_read_oor: got %h/%b want 00000000/10", rd, rr);
        end
    endtask

    task automatic test_collision();
        logic [31:0] old_d, new_d, rd;
        logic [1:0]  rr;
        old_d = mdl_read(32'h10C);
        new_d = $urandom;
        s_AWVALID = 1; s_AWADDR = 32'h10C;
        s_WVALID = 1;  s_WDATA = new_d; s_WSTRB = 4'hF;
        s_ARVALID = 1; s_ARADDR = 32'h10C;
        @(posedge clk); #1;
        s_AWVALID = 0; s_WVALID = 0; s_ARVALID = 0;
        checks++;
        if (s_BVALID !== 1'b1 || s_BRESP !== 2'b00 || s_RVALID !== 1'b1 || s_RDATA !== old_d) begin
            errors++;
            $display("FAIL collision_prewrite: BV=%b BRESP=%b RV=%b RDATA=%h, want 1 00 1 %h",
                     s_BVALID, s_BRESP, s_RVALID, s_RDATA, old_d);
        end
        void'(mdl_write(32'h10C, new_d, 4'hF));
        s_BREADY = 1; s_RREADY = 1;
        @(posedge clk); #1;
        s_BREADY = 0; s_RREADY = 0;
        do_read(32'h10C, 0, rd, rr);
        checks++;
        if (rd !== new_d) begin errors++; $display("FAIL collision_postwrite: got %h want %h", rd, new_d); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] wa, ra, d, rd, exp_d;
            logic [3:0]  s;
            logic [1:0]  br, rr, exp_b, exp_r;
            int          wi, ri;
            wi = $urandom_range(0, DEPTH - 1);
            ri = (wi + $urandom_range(1, DEPTH - 1)) % DEPTH;
            wa = BASE + 32'(4 * wi) + 32'($urandom_range(0, 3));
            ra = BASE + 32'(4 * ri) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) wa = ($urandom_range(0, 1) != 0) ? 32'h0F0 + 32'($urandom_range(0, 15))
                                                                        : 32'h200 + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) ra = 32'h200 + 32'($urandom_range(0, 255));
            d = $urandom; s = 4'($urandom);
            exp_d = mdl_read(ra); exp_r = mdl_resp(ra);
            fork
                do_write(wa, d, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), br);
                do_read(ra, $urandom_range(0, 2), rd, rr);
            join
            exp_b = mdl_write(wa, d, s);
            checks++;
            if (br !== exp_b) begin errors++; $display("FAIL rand_bresp n=%0d addr=%h: got %b want %b", n, wa, br, exp_b); end
            checks++;
            if (rd !== exp_d || rr !== exp_r) begin
                errors++; $display("FAIL rand_read n=%0d addr=%h: got %h/%b want %h/%b", n, ra, rd, rr, exp_d, exp_r);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [1:0]  br, rr;
        void'(mdl_write(32'h100, 32'hFEEDF00D, 4'hF));
        do_write(32'h100, 32'hFEEDF00D, 4'hF, 0, 0, 0, br);
        s_AWVALID = 1; s_AWADDR = 32'h100;
        s_ARVALID = 1; s_ARADDR = 32'h100;
        @(posedge clk); #1;
        s_AWVALID = 0; s_ARVALID = 0;
        checks++;
        if (s_RVALID !== 1'b1 || s_BVALID !== 1'b0 || s_WREADY !== 1'b1) begin
            errors++; $display("FAIL midrst_setup: RV=%b BV=%b WREADY=%b, want 1 0 1", s_RVALID, s_BVALID, s_WREADY);
        end
        rst_n = 0;
        #1;
        checks++;
        if (s_AWREADY !== 1'b0 || s_WREADY !== 1'b0 || s_ARREADY !== 1'b0) begin
            errors++; $display("FAIL midrst_ready: AW/W/AR READY=%b%b%b, want 000", s_AWREADY, s_WREADY, s_ARREADY);
        end
        @(posedge clk); #1;
        rst_n = 1;
        mdl_clear();
        checks++;
        if (s_BVALID !== 1'b0 || s_RVALID !== 1'b0 || s_RDATA !== 32'h0 || s_RRESP !== 2'b00 || s_BRESP !== 2'b00) begin
            errors++;
            $display("FAIL midrst_outputs: BV=%b RV=%b RDATA=%h RRESP=%b BRESP=%b, want 0 0 0 00 00",
                     s_BVALID, s_RVALID, s_RDATA, s_RRESP, s_BRESP);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (s_BVALID !== 1'b0 || s_RVALID !== 1'b0) begin
                errors++; $display("FAIL midrst_stale cyc=%0d: BV=%b RV=%b, want 0 0", i, s_BVALID, s_RVALID);
            end
        end
        void'(mdl_write(32'h104, 32'h0BADCAFE, 4'hF));
        do_write(32'h104, 32'h0BADCAFE, 4'hF, 3, 0, 0, br);
        checks++;
        if (br !== 2'b00) begin errors++; $display("FAIL midrst_bresp: got %b want 00", br); end
        for (int w = 0; w < 6; w++) begin
            do_read(BASE + 32'(4 * w), 0, rd, rr);
            checks++;
            if (rd !== model[w] || rr !== 2'b00) begin
                errors++; $display("FAIL midrst_mem word=%0d: got %h/%b want %h/00", w, rd, rr, model[w]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_split();
        test_strobe();
        test_out_of_range();
        test_backpressure();
        test_collision();
        test_random();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4_lite_sram_slave.md
AXI4_LITE_SRAM_SLAVE -- requirements
Module: axi4_lite_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width; only 32 is supported.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h00000100: byte address of word 0.
REQ-004 SHALL have parameter DEPTH, default 64: number of 32-bit words.
REQ-005 SHALL have ports:
- iCLK  in  1  sole clock, rising edge.
- iRST  in  1  synchronous, active-low reset.
- s_AWVALID, s_AWADDR[ADDR_WIDTH], s_AWPROT[3]  in; s_AWREADY  out.
- s_WVALID, s_WDATA[32], s_WSTRB[4]  in; s_WREADY  out.
- s_BREADY  in; s_BVALID, s_BRESP[2]  out.
- s_ARVALID, s_ARADDR[ADDR_WIDTH], s_ARPROT[3]  in; s_ARREADY  out.
- s_RREADY  in; s_RVALID, s_RRESP[2], s_RDATA[32]  out.
REQ-006 SHALL accept AWPROT/ARPROT and otherwise ignore them.

Function
REQ-007 SHALL decode the word index as (addr - BASE_ADDR) >> 2 and ignore addr[1:0].
REQ-008 SHALL treat an address as in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH.
REQ-009 Write FSM SHALL use the states WR_IDLE, WR_WAIT_W (address held), WR_WAIT_A (data held) and WR_RESP.
REQ-010 SHALL drive s_AWREADY=1 in WR_IDLE and WR_WAIT_A, else 0.
REQ-011 SHALL drive s_WREADY=1 in WR_IDLE and WR_WAIT_W, else 0.
REQ-012 WR_IDLE transitions:
- AW and W handshakes in the same cycle -> WR_RESP.
- AW handshake only -> WR_WAIT_W, capturing the address.
- W handshake only -> WR_WAIT_A, capturing data and strobe.
REQ-013 WR_WAIT_W SHALL go to WR_RESP on a W handshake; WR_WAIT_A SHALL go to WR_RESP on an AW handshake.
REQ-014 At the edge that completes the AW/W pair, if in range, SHALL update each byte lane i where WSTRB[i]=1; lanes with WSTRB[i]=0 SHALL be left unchanged.
REQ-015 SHALL assert s_BVALID on the cycle after that edge, with s_BRESP=2'b00 in range or 2'b10 (SLVERR) out of range; an out-of-range write SHALL NOT modify memory.
REQ-016 SHALL hold s_BVALID and s_BRESP stable until s_BREADY=1, then deassert s_BVALID and return to WR_IDLE; the next AW/W SHALL be accepted no earlier than the following cycle.
REQ-017 Read FSM SHALL use the states RD_IDLE (s_ARREADY=1) and RD_RESP (s_ARREADY=0).
REQ-018 On an AR handshake SHALL register s_RDATA from memory (32'h0 if out of range) and s_RRESP (2'b00 in range / 2'b10 out of range), and assert s_RVALID on the next cycle.
REQ-019 SHALL hold s_RVALID, s_RDATA and s_RRESP stable until s_RREADY=1, then return to RD_IDLE.
REQ-020 Read and write channels SHALL operate concurrently and independently.
REQ-021 An AR handshake on the same edge as a write commit to the same word SHALL return the pre-write data.
REQ-022 WSTRB=4'b0000 in range SHALL produce OKAY with no memory change.

Reset
REQ-023 While iRST=0 at a rising edge, SHALL put both FSMs in IDLE and drive:
- s_BVALID=0, s_RVALID=0;
- s_BRESP=2'b00, s_RRESP=2'b00, s_RDATA=32'h0;
- all memory words to 32'h0.
REQ-024 While iRST=0, SHALL force s_AWREADY, s_WREADY and s_ARREADY to 0.
REQ-025 Reset mid-transaction SHALL discard held address/data and pending responses; no response SHALL be issued for them afterwards.

Structure
REQ-026 Shared package axi4_lite_pkg SHALL hold RESP_OKAY=2'b00, RESP_SLVERR=2'b10 and the write/read FSM state encodings.
REQ-027 The byte-strobed memory array (one write port with 4-bit byte enable, one registered read port, synchronous clear) SHALL be a sub-module named axi4_lite_strb_ram.

Verification
REQ-028 Write 0x100 data 32'hDEADBEEF strb 4'hF (AW, W same cycle), then read 0x100 -> BRESP=00 one cycle after the handshake; RDATA=32'hDEADBEEF, RRESP=00.
REQ-029 W of 32'h11223344 strb 4'hF, then AW 0x104 three cycles later (and reversed order) -> one BVALID only after both; read 0x104=32'h11223344.
REQ-030 Write 0x108=32'hAABBCCDD, then write 32'h00000055 strb 4'b0001 -> read 0x108=32'hAABBCC55.
REQ-031 Write 0x200 and read 0x0FC -> BRESP=10; RRESP=10 with RDATA=0; no word changed.
REQ-032 Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and payload stable throughout, with AWREADY/WREADY/ARREADY low.
REQ-033 Assert iRST=0 while in WR_WAIT_W and RD_RESP -> next cycle all VALIDs 0, FSMs IDLE, memory reads 0, no stale B or R response.
